fraction_mac4_ctrl: RTL and testbench

Sequencer and accumulator wrapped around the 4-bit signed fractional multiplier (Q1.3 x Q1.3 -> Q1.6, St/Done protocol).
- Upstream side: accepts operand pairs over a valid/ready handshake, loads the multiplier and pulses St.
- Downstream side: waits for Done, captures the 7-bit product and adds it, sign-extended and saturating, into a running accumulator.
- On the operand flagged last, presents the accumulated dot-product on a valid/ready output.

---
 rtl/fraction_mac4_ctrl_if.sv | 35 +++
 rtl/fraction_mac4_ctrl.sv | 148 ++++++++++++++
 tb/tb_fraction_mac4_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fraction_mac4_ctrl_if.sv
// Handshake and multiplier-side bundle for fraction_mac4_ctrl.
// The master side drives operands, multiplier results and the result-ready signal.
interface fraction_mac4_ctrl_if #(
   parameter int ACC_W = 10,
   parameter int CNT_W = 8
);
   logic             In_Valid;
   logic             In_Ready;
   logic [3:0]       In_A;
   logic [3:0]       In_B;
   logic             In_Last;
   logic             Mul_St;
   logic [3:0]       Mul_Mplier;
   logic [3:0]       Mul_Mcand;
   logic [6:0]       Mul_Product;
   logic             Mul_Done;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [ACC_W-1:0] Out_Acc;
   logic [CNT_W-1:0] Out_Count;
   logic             Out_Sat;
   logic             Out_Err;

   modport master (
      output In_Valid, In_A, In_B, In_Last, Mul_Product, Mul_Done, Out_Ready,
      input  In_Ready, Mul_St, Mul_Mplier, Mul_Mcand, Out_Valid, Out_Acc,
             Out_Count, Out_Sat, Out_Err
   );

   modport slave (
      input  In_Valid, In_A, In_B, In_Last, Mul_Product, Mul_Done, Out_Ready,
      output In_Ready, Mul_St, Mul_Mplier, Mul_Mcand, Out_Valid, Out_Acc,
             Out_Count, Out_Sat, Out_Err
   );
endinterface

// File: rtl/fraction_mac4_ctrl.sv
// Sequences a Q1.3 x Q1.3 St/Done multiplier and accumulates its Q1.6 products
// into a saturating Q(ACC_W-6).6 dot-product presented over valid/ready.
module fraction_mac4_ctrl #(
   parameter int ACC_W     = 10,
   parameter int CNT_W     = 8,
   parameter int TIMEOUT   = 32,
   parameter int FLUSH_CYC = 12
) (
   input  logic                 CLK,
   input  logic                 Rst,
   fraction_mac4_ctrl_if.slave  bus
);
   localparam int FW = $clog2(FLUSH_CYC + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FLUSH, S_IDLE, S_START, S_WAIT, S_ACC, S_OUT, S_ERR
   } state_t;

   state_t state, state_nxt;

   logic [FW-1:0]    flush_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic [3:0]       mplier, mcand;
   logic             last_q;
   logic [6:0]       prod_q;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             sat;

   logic [ACC_W:0]   sum_wide;
   logic             ovf_pos, ovf_neg;
   logic [ACC_W-1:0] acc_nxt;

   // state register
   always_ff @(posedge CLK) begin
      if (Rst) state <= S_FLUSH;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_IDLE;
         S_IDLE:  if (bus.In_Valid) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus.Mul_Done)             state_nxt = S_ACC;
            else if (tmo_cnt == TMO_LAST) state_nxt = S_ERR;
         end
         S_ACC:   state_nxt = last_q ? S_OUT : S_IDLE;
         S_OUT:   if (bus.Out_Ready) state_nxt = S_IDLE;
         S_ERR:   if (bus.Out_Ready) state_nxt = S_FLUSH;
         default: state_nxt = S_FLUSH;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      bus.In_Ready  = 1'b0;
      bus.Mul_St    = 1'b0;
      bus.Out_Valid = 1'b0;
      bus.Out_Err   = 1'b0;
      case (state)
         S_IDLE:  bus.In_Ready = 1'b1;
         S_START: bus.Mul_St   = 1'b1;
         S_OUT:   bus.Out_Valid = 1'b1;
         S_ERR: begin
            bus.Out_Valid = 1'b1;
            bus.Out_Err   = 1'b1;
         end
         default: ;
      endcase
   end

   // Sum one bit wider than the accumulator; a sign/carry disagreement flags overflow.
   always_comb begin
      sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-6){prod_q[6]}}, prod_q};
      ovf_pos  = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
      ovf_neg  =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
      if (ovf_pos)      acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
      else if (ovf_neg) acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      else              acc_nxt = sum_wide[ACC_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (Rst) begin
         flush_cnt <= '0;
         tmo_cnt   <= '0;
         mplier    <= '0;
         mcand     <= '0;
         last_q    <= 1'b0;
         prod_q    <= '0;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
      end else begin
         flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
         case (state)
            S_IDLE: begin
               if (bus.In_Valid) begin
                  mplier <= bus.In_A;
                  mcand  <= bus.In_B;
                  last_q <= bus.In_Last;
               end
            end
            S_START: tmo_cnt <= '0;
            S_WAIT: begin
               if (bus.Mul_Done) prod_q  <= bus.Mul_Product;
               else              tmo_cnt <= tmo_cnt + 1'b1;
            end
            S_ACC: begin
               acc <= acc_nxt;
               sat <= sat | ovf_pos | ovf_neg;
               if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
            end
            S_OUT: begin
               if (bus.Out_Ready) begin
                  acc <= '0;
                  cnt <= '0;
                  sat <= 1'b0;
               end
            end
            S_ERR: begin
               if (bus.Out_Ready) begin
                  acc    <= '0;
                  cnt    <= '0;
                  sat    <= 1'b0;
                  mplier <= '0;
                  mcand  <= '0;
                  last_q <= 1'b0;
                  prod_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Mul_Mplier = mplier;
   assign bus.Mul_Mcand  = mcand;
   assign bus.Out_Acc    = acc;
   assign bus.Out_Count  = cnt;
   assign bus.Out_Sat    = sat;
endmodule

// File: tb/tb_fraction_mac4_ctrl.sv
// Bench for fraction_mac4_ctrl: a task-driven multiplier stand-in plus an
// integer dot-product reference with clamping.
module tb_fraction_mac4_ctrl;
   localparam int ACC_W = 10;
   localparam int CNT_W = 8;
   localparam int AMAX  = 2**(ACC_W-1) - 1;
   localparam int AMIN  = -(2**(ACC_W-1));
   localparam int CMAX  = 2**CNT_W - 1;

   logic CLK = 1'b0;
   logic Rst = 1'b1;
   always #5 CLK = ~CLK;

   fraction_mac4_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   fraction_mac4_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W), .TIMEOUT(32), .FLUSH_CYC(12)) dut (
      .CLK(CLK),
      .Rst(Rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int r_acc = 0;
   int r_cnt = 0;
   int r_sat = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int sx4(input logic [3:0] v);
      return int'($signed(v));
   endfunction

   // 7-bit wrapped product, as a 4x4 signed multiplier with a Q1.6 port delivers it
   function automatic int prod7(input logic [3:0] a, input logic [3:0] b);
      logic [6:0] t;
      t = 7'(sx4(a) * sx4(b));
      return int'($signed(t));
   endfunction

   task automatic ref_add(input int p);
      r_acc = r_acc + p;
      if (r_acc > AMAX) begin r_acc = AMAX; r_sat = 1; end
      else if (r_acc < AMIN) begin r_acc = AMIN; r_sat = 1; end
      if (r_cnt < CMAX) r_cnt++;
   endtask

   task automatic ref_clear();
      r_acc = 0; r_cnt = 0; r_sat = 0;
   endtask

   function automatic int acc_s();
      return int'($signed(bus.Out_Acc));
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!bus.In_Ready && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!bus.In_Ready) chk("in_ready_timeout", 0, 1);
   endtask

   task automatic present(input logic [3:0] a, input logic [3:0] b, input logic last);
      wait_ready();
      bus.In_Valid = 1'b1; bus.In_A = a; bus.In_B = b; bus.In_Last = last;
      @(negedge CLK);
      bus.In_Valid = 1'b0; bus.In_A = 4'($urandom); bus.In_B = 4'($urandom);
      chk("st_pulse", int'(bus.Mul_St), 1);
      chk("mplier", int'(bus.Mul_Mplier), int'(a));
      chk("mcand", int'(bus.Mul_Mcand), int'(b));
      chk("ready_busy", int'(bus.In_Ready), 0);
   endtask

   task automatic send_term(input logic [3:0] a, input logic [3:0] b, input logic last,
                            input int lat, input bit stale);
      present(a, b, last);
      if (stale) begin
         bus.Mul_Done = 1'b1; bus.Mul_Product = 7'($urandom);
      end
      @(negedge CLK);
      bus.Mul_Done = 1'b0;
      chk("st_once", int'(bus.Mul_St), 0);
      repeat (lat) @(negedge CLK);
      chk("mplier_hold", int'(bus.Mul_Mplier), int'(a));
      bus.Mul_Product = 7'(prod7(a, b)); bus.Mul_Done = 1'b1;
      @(negedge CLK);
      bus.Mul_Done = 1'b0; bus.Mul_Product = 7'($urandom);
      ref_add(prod7(a, b));
      @(negedge CLK);
   endtask

   task automatic check_result(input int err);
      chk("out_valid", int'(bus.Out_Valid), 1);
      chk("out_err", int'(bus.Out_Err), err);
      chk("out_acc", acc_s(), r_acc);
      chk("out_count", int'(bus.Out_Count), r_cnt);
      chk("out_sat", int'(bus.Out_Sat), r_sat);
   endtask

   task automatic consume(input int hold);
      repeat (hold) begin
         @(negedge CLK);
         chk("hold_valid", int'(bus.Out_Valid), 1);
         chk("hold_acc", acc_s(), r_acc);
         chk("hold_count", int'(bus.Out_Count), r_cnt);
      end
      bus.Out_Ready = 1'b1;
      @(negedge CLK);
      bus.Out_Ready = 1'b0;
      ref_clear();
      chk("post_valid", int'(bus.Out_Valid), 0);
      chk("post_acc", acc_s(), 0);
      chk("post_count", int'(bus.Out_Count), 0);
      chk("post_sat", int'(bus.Out_Sat), 0);
      chk("post_err", int'(bus.Out_Err), 0);
   endtask

   task automatic check_flush();
      for (int i = 0; i < 12; i++) begin
         chk("flush_ready", int'(bus.In_Ready), 0);
         chk("flush_st", int'(bus.Mul_St), 0);
         @(negedge CLK);
      end
      chk("idle_ready", int'(bus.In_Ready), 1);
   endtask

   task automatic run_txn(input int n, input bit extreme);
      logic [3:0] a, b;
      logic [3:0] pick [4];
      pick[0] = 4'b1000; pick[1] = 4'b0111; pick[2] = 4'b1001; pick[3] = 4'b1111;
      for (int i = 0; i < n; i++) begin
         if (extreme) begin
            a = pick[$urandom_range(0, 3)]; b = pick[$urandom_range(0, 3)];
         end else begin
            a = 4'($urandom); b = 4'($urandom);
         end
         send_term(a, b, (i == n - 1), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
      end
      check_result(0);
      consume($urandom_range(0, 3));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.In_Valid = 0; bus.In_A = 0; bus.In_B = 0; bus.In_Last = 0;
      bus.Mul_Product = 0; bus.Mul_Done = 0; bus.Out_Ready = 0;
      repeat (2) @(negedge CLK);
      chk("rst_ready", int'(bus.In_Ready), 0);
      chk("rst_st", int'(bus.Mul_St), 0);
      chk("rst_mplier", int'(bus.Mul_Mplier), 0);
      chk("rst_mcand", int'(bus.Mul_Mcand), 0);
      chk("rst_valid", int'(bus.Out_Valid), 0);
      chk("rst_acc", acc_s(), 0);
      chk("rst_count", int'(bus.Out_Count), 0);
      chk("rst_sat", int'(bus.Out_Sat), 0);
      chk("rst_err", int'(bus.Out_Err), 0);
      Rst = 1'b0;
      check_flush();

      // single term 0.25
      send_term(4'b0100, 4'b0100, 1'b1, 2, 1'b0);
      chk("single_acc_const", acc_s(), 16);
      check_result(0);
      consume(0);

      // three terms of 0.5 x 0.5, result held for 5 cycles
      for (int i = 0; i < 3; i++) send_term(4'b0100, 4'b0100, (i == 2), 1, (i == 1));
      chk("three_acc_const", acc_s(), 48);
      check_result(0);
      consume(5);

      // positive and negative saturation
      for (int i = 0; i < 12; i++) send_term(4'b1000, 4'b1001, (i == 11), 0, 1'b0);
      chk("sat_pos_const", acc_s(), AMAX);
      check_result(0);
      consume(1);
      for (int i = 0; i < 12; i++) send_term(4'b0111, 4'b1000, (i == 11), 3, 1'b0);
      chk("sat_neg_const", acc_s(), AMIN);
      check_result(0);
      consume(1);

      // count holds at all-ones
      for (int i = 0; i < CMAX + 5; i++) send_term(4'b0000, 4'($urandom), (i == CMAX + 4), 0, 1'b0);
      chk("count_hold_const", int'(bus.Out_Count), CMAX);
      check_result(0);
      consume(0);

      // timeout with one term already accumulated
      send_term(4'b0011, 4'b0101, 1'b0, 1, 1'b0);
      present(4'b0101, 4'b0101, 1'b1);
      @(negedge CLK);
      for (int i = 0; i < 32; i++) begin
         chk("tmo_wait_valid", int'(bus.Out_Valid), 0);
         @(negedge CLK);
      end
      check_result(1);
      consume(2);
      check_flush();

      // reset while waiting on the multiplier
      send_term(4'b0110, 4'b0101, 1'b0, 1, 1'b0);
      present(4'b0010, 4'b0011, 1'b1);
      @(negedge CLK);
      chk("pre_rst_acc", acc_s(), r_acc);
      Rst = 1'b1;
      @(negedge CLK);
      Rst = 1'b0;
      ref_clear();
      chk("midrst_acc", acc_s(), 0);
      chk("midrst_count", int'(bus.Out_Count), 0);
      chk("midrst_valid", int'(bus.Out_Valid), 0);
      check_flush();
      run_txn(3, 1'b0);

      // randomized accumulations
      for (int t = 0; t < 40; t++) run_txn($urandom_range(1, 14), ($urandom_range(0, 2) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
